// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - POR release synchroniser and ordered multi-domain reset sequencer (optional watchdog: RESET_SEQUENCER_WDT_EN)
module reset_sequencer #(
    parameter int NUM_DOMAINS      = 3,
    parameter int SYNC_STAGES      = 2,
    parameter int HOLD_CYCLES      = 16,
    parameter int STAGE_GAP        = 4,
    parameter int SOFT_HOLD_CYCLES = 8,
    parameter int WDT_CYCLES       = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   soft_rst_req_i,
`ifdef RESET_SEQUENCER_WDT_EN
    input  logic                   wdt_kick_i,
`endif
    output logic [NUM_DOMAINS-1:0] rst_no,
    output logic                   ready_o,
    output logic                   busy_o,
    output logic [1:0]             cause_o
);

    localparam int CNT_MAX_A = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_MAX   = (CNT_MAX_A > SOFT_HOLD_CYCLES) ? CNT_MAX_A : SOFT_HOLD_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX) + 1;
    localparam int IDX_W     = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [1:0]       CAUSE_POR  = 2'b00;
    localparam logic [1:0]       CAUSE_SOFT = 2'b01;
    localparam logic [1:0]       CAUSE_WDT  = 2'b10;

    // Refuse to elaborate with out-of-range parameters
    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8 || SYNC_STAGES < 2 || HOLD_CYCLES < 1 ||
        STAGE_GAP < 1 || SOFT_HOLD_CYCLES < 1 || WDT_CYCLES < 1) begin : g_bad_param
        $error("reset_sequencer: illegal parameter value");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_SOFT_HOLD,
        ST_SOFT_RELEASE
    } state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NUM_DOMAINS-1:0]   rst_q, rst_d;
    logic                     ready_q, ready_d;
    logic                     busy_q, busy_d;
    logic [1:0]               cause_q, cause_d;
    logic                     step_due;
    logic                     wdt_expired;

`ifdef RESET_SEQUENCER_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES) + 1;

    logic [WDT_W-1:0] wdt_q, wdt_d;

    // Watchdog counts RUN cycles since the last kick; any other state clears it
    always_comb begin
        if (state_q != ST_RUN || wdt_kick_i) begin
            wdt_d = '0;
        end else if (wdt_q == WDT_W'(WDT_CYCLES)) begin
            wdt_d = wdt_q;
        end else begin
            wdt_d = wdt_q + WDT_W'(1);
        end
    end

    assign wdt_expired = (state_q == ST_RUN) && !wdt_kick_i && (wdt_q == WDT_W'(WDT_CYCLES - 1));

    // Watchdog counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    assign wdt_expired = 1'b0;
`endif

    // Next-state logic: synchroniser shift, stage counters and per-domain release
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], 1'b1};
        state_d  = state_q;
        cnt_d    = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        rst_d    = rst_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        cause_d  = cause_q;
        step_due = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Last synchroniser stage is about to capture its first 1 (E0)
                if (!sync_q[SYNC_STAGES-1] && sync_q[SYNC_STAGES-2]) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    rst_d[0] = 1'b1;
                    cnt_d    = '0;
                    idx_d    = IDX_W'(1);
                    if (NUM_DOMAINS == 1) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE, ST_SOFT_HOLD, ST_SOFT_RELEASE: begin
                if (state_q == ST_SOFT_HOLD) begin
                    step_due = (cnt_q == CNT_W'(SOFT_HOLD_CYCLES - 1));
                end else begin
                    step_due = (cnt_q == CNT_W'(STAGE_GAP - 1));
                end
                if (step_due) begin
                    for (int k = 0; k < NUM_DOMAINS; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            rst_d[k] = 1'b1;
                        end
                    end
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (state_q == ST_SOFT_HOLD) begin
                            state_d = ST_SOFT_RELEASE;
                        end
                    end
                end
            end
            ST_RUN: begin
                // Domain 0 survives a soft/watchdog sequence; nothing to do with one domain
                if (NUM_DOMAINS > 1 && (soft_rst_req_i || wdt_expired)) begin
                    state_d = ST_SOFT_HOLD;
                    cnt_d   = '0;
                    idx_d   = IDX_W'(1);
                    rst_d   = NUM_DOMAINS'(1);
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    cause_d = soft_rst_req_i ? CAUSE_SOFT : CAUSE_WDT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; POR clears everything without a clock
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            cause_q <= CAUSE_POR;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
        end
    end

    assign rst_no  = rst_q;
    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign cause_o = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer output transitions
module tb_reset_sequencer;

`ifdef RESET_SEQUENCER_WDT_EN
    localparam int NCH = 3;
`else
    localparam int NCH = 2;
`endif

    typedef struct {
        int          edge_n;
        logic [11:0] val;
    } exp_t;

    logic        clk = 1'b0;
    int          edge_cnt = 0;
    int          n_total = 0;
    int          n_pass = 0;

    exp_t        sbq [NCH][$];
    logic [11:0] obs [NCH];
    logic [11:0] prev [NCH];

    logic        rst_a = 1'b1;
    logic        req_a = 1'b0;
    logic [2:0]  rst_no_a;
    logic        ready_a, busy_a;
    logic [1:0]  cause_a;

    logic        rst_b = 1'b1;
    logic        req_b = 1'b0;
    logic [0:0]  rst_no_b;
    logic        ready_b, busy_b;
    logic [1:0]  cause_b;

    reset_sequencer u_main (
        .clk_i          (clk),
        .rst_ni         (rst_a),
        .soft_rst_req_i (req_a),
`ifdef RESET_SEQUENCER_WDT_EN
        .wdt_kick_i     (1'b1),
`endif
        .rst_no         (rst_no_a),
        .ready_o        (ready_a),
        .busy_o         (busy_a),
        .cause_o        (cause_a)
    );

    reset_sequencer #(
        .NUM_DOMAINS (1),
        .HOLD_CYCLES (1),
        .SYNC_STAGES (3)
    ) u_one (
        .clk_i          (clk),
        .rst_ni         (rst_b),
        .soft_rst_req_i (req_b),
`ifdef RESET_SEQUENCER_WDT_EN
        .wdt_kick_i     (1'b1),
`endif
        .rst_no         (rst_no_b),
        .ready_o        (ready_b),
        .busy_o         (busy_b),
        .cause_o        (cause_b)
    );

    assign obs[0] = {5'b0, rst_no_a, ready_a, busy_a, cause_a};
    assign obs[1] = {7'b0, rst_no_b, ready_b, busy_b, cause_b};

`ifdef RESET_SEQUENCER_WDT_EN
    logic        rst_w = 1'b1;
    logic        req_w = 1'b0;
    logic        kick_w = 1'b0;
    logic [2:0]  rst_no_w;
    logic        ready_w, busy_w;
    logic [1:0]  cause_w;

    reset_sequencer #(
        .WDT_CYCLES (16)
    ) u_wdt (
        .clk_i          (clk),
        .rst_ni         (rst_w),
        .soft_rst_req_i (req_w),
        .wdt_kick_i     (kick_w),
        .rst_no         (rst_no_w),
        .ready_o        (ready_w),
        .busy_o         (busy_w),
        .cause_o        (cause_w)
    );

    assign obs[2] = {5'b0, rst_no_w, ready_w, busy_w, cause_w};
`endif

    function automatic logic [11:0] mk(input int r, input int rd, input int bs, input int c);
        return {r[7:0], rd[0], bs[0], c[1:0]};
    endfunction

    task automatic push(input int ch, input int e, input int r, input int rd, input int bs, input int c);
        exp_t x;
        x.edge_n = e;
        x.val    = mk(r, rd, bs, c);
        sbq[ch].push_back(x);
    endtask

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic goto(input int n);
        while (edge_cnt < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    // Monitor: every change on a DUT's outputs must match the next queued transition
    initial begin
        exp_t x;
        for (int i = 0; i < NCH; i++) prev[i] = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) begin
                if (obs[i] !== prev[i]) begin
                    prev[i] = obs[i];
                    n_total++;
                    if (sbq[i].size() == 0) begin
                        $display("FAIL ch%0d unexpected transition: got %h at edge %0d, required no change",
                                 i, obs[i], edge_cnt);
                    end else begin
                        x = sbq[i].pop_front();
                        if (x.edge_n == edge_cnt && x.val === obs[i]) n_pass++;
                        else $display("FAIL ch%0d transition: got %h at edge %0d, required %h at edge %0d",
                                      i, obs[i], edge_cnt, x.val, x.edge_n);
                    end
                end
            end
        end
    end

    // Default instance: POR, mid-sequence reset, ignored request, soft resets
    initial begin
        rst_a = 1'b0;
        #1 check("a_reset_state", obs[0], mk(0, 0, 0, 0));
        push(0, 2, 0, 0, 1, 0);
        push(0, 18, 1, 0, 1, 0);
        push(0, 20, 0, 0, 0, 0);
        #1 rst_a = 1'b1;
        goto(20);
        rst_a = 1'b0;
        #1 check("a_async_reset", obs[0], mk(0, 0, 0, 0));
        push(0, 23, 0, 0, 1, 0);
        push(0, 39, 1, 0, 1, 0);
        push(0, 43, 3, 0, 1, 0);
        push(0, 47, 7, 1, 0, 0);
        goto(21);
        rst_a = 1'b1;
        goto(24);
        req_a = 1'b1;
        goto(27);
        req_a = 1'b0;
        goto(50);
        check("a_run_por", obs[0], mk(7, 1, 0, 0));
        push(0, 100, 1, 0, 1, 1);
        push(0, 108, 3, 0, 1, 1);
        push(0, 112, 7, 1, 0, 1);
        goto(99);
        req_a = 1'b1;
        goto(100);
        req_a = 1'b0;
        goto(105);
        check("a_soft_hold", obs[0], mk(1, 0, 1, 1));
        push(0, 130, 1, 0, 1, 1);
        push(0, 138, 3, 0, 1, 1);
        push(0, 142, 7, 1, 0, 1);
        push(0, 143, 1, 0, 1, 1);
        push(0, 151, 3, 0, 1, 1);
        push(0, 155, 7, 1, 0, 1);
        goto(129);
        req_a = 1'b1;
        goto(143);
        req_a = 1'b0;
        goto(160);
        check("a_final", obs[0], mk(7, 1, 0, 1));
    end

    // Single-domain instance: E0 at edge 3, release at edge 4, soft requests ignored
    initial begin
        rst_b = 1'b0;
        #1 check("b_reset_state", obs[1], mk(0, 0, 0, 0));
        push(1, 3, 0, 0, 1, 0);
        push(1, 4, 1, 1, 0, 0);
        #1 rst_b = 1'b1;
        goto(10);
        req_b = 1'b1;
        goto(13);
        req_b = 1'b0;
        goto(20);
        check("b_soft_ignored", obs[1], mk(1, 1, 0, 0));
    end

`ifdef RESET_SEQUENCER_WDT_EN
    // Watchdog instance: kicks keep it quiet, then a timeout, then soft+kick together
    initial begin
        rst_w = 1'b0;
        #1 check("w_reset_state", obs[2], mk(0, 0, 0, 0));
        push(2, 2, 0, 0, 1, 0);
        push(2, 18, 1, 0, 1, 0);
        push(2, 22, 3, 0, 1, 0);
        push(2, 26, 7, 1, 0, 0);
        #1 rst_w = 1'b1;
        for (int k = 30; k <= 60; k += 10) begin
            goto(k - 1);
            kick_w = 1'b1;
            goto(k);
            kick_w = 1'b0;
        end
        push(2, 76, 1, 0, 1, 2);
        push(2, 84, 3, 0, 1, 2);
        push(2, 88, 7, 1, 0, 2);
        goto(80);
        check("w_timeout", obs[2], mk(1, 0, 1, 2));
        push(2, 100, 1, 0, 1, 1);
        push(2, 108, 3, 0, 1, 1);
        push(2, 112, 7, 1, 0, 1);
        goto(99);
        req_w  = 1'b1;
        kick_w = 1'b1;
        goto(100);
        req_w  = 1'b0;
    end
`endif

    initial begin
        exp_t x;
        goto(170);
        for (int i = 0; i < NCH; i++) begin
            while (sbq[i].size() > 0) begin
                x = sbq[i].pop_front();
                n_total++;
                $display("FAIL ch%0d missing transition: got none, required %h at edge %0d", i, x.val, x.edge_n);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
